// File: rtl/uart_tx_port.sv
// rtl/uart_tx_port.sv - memory-mapped 8N1 UART transmitter with byte FIFO and level interrupt
module uart_tx_port #(
  parameter logic [15:0] DEFAULT_DIV = 16'd433,
  parameter int          FIFO_AW     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        txd,
  output logic        tx_int
);

  localparam int CW = FIFO_AW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(2 ** FIFO_AW);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state;
  logic [7:0]         mem [0:2**FIFO_AW-1];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic [7:0]         shift;
  logic [15:0]        div_lat, div_cnt, bauddiv;
  logic [2:0]         bit_idx;
  logic               overflow, tx_en, int_en;
  logic               full, empty, busy, bit_end;
  logic               wr_txdata, wr_status, wr_baud, wr_ctrl;
  logic               push, push_ok, pop;
  logic               unused_bits;

  assign full      = (count == DEPTH);
  assign empty     = (count == '0);
  assign busy      = (state != IDLE);
  assign bit_end   = (div_cnt == div_lat);
  assign wr_txdata = ce & we & (addr[3:2] == 2'd0);
  assign wr_status = ce & we & (addr[3:2] == 2'd1);
  assign wr_baud   = ce & we & (addr[3:2] == 2'd2);
  assign wr_ctrl   = ce & we & (addr[3:2] == 2'd3);
  assign push      = wr_txdata & sel[0];
  assign push_ok   = push & ~full;
  // pop only at a frame boundary: from IDLE, or on the last stop-bit cycle
  assign pop       = tx_en & ~empty & ((state == IDLE) | ((state == STOP) & bit_end));
  assign unused_bits = ^{addr[31:4], addr[1:0], data_i[31:16], sel[3:2]};

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data_i[7:0];
  end

  // FIFO pointers and occupancy; push and pop in one cycle leave count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)     rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // software-visible registers: sticky overflow, baud divisor, control bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      bauddiv  <= DEFAULT_DIV;
      tx_en    <= 1'b1;
      int_en   <= 1'b0;
    end else begin
      if (push & full)    overflow <= 1'b1;
      else if (wr_status) overflow <= 1'b0;
      if (wr_baud & sel[0]) bauddiv[7:0]  <= data_i[7:0];
      if (wr_baud & sel[1]) bauddiv[15:8] <= data_i[15:8];
      if (wr_ctrl & sel[0]) begin
        tx_en  <= data_i[0];
        int_en <= data_i[1];
      end
    end
  end

  // serializer: divisor latched at frame start, txd registered with the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shift   <= '0;
      div_lat <= '0;
      div_cnt <= '0;
      bit_idx <= '0;
      txd     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            shift   <= mem[rd_ptr];
            div_lat <= bauddiv;
            div_cnt <= '0;
            state   <= START;
            txd     <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            div_cnt <= '0;
            bit_idx <= '0;
            txd     <= shift[0];
            state   <= DATA;
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            div_cnt <= '0;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= shift[bit_idx + 3'd1];
            end
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            div_cnt <= '0;
            if (pop) begin
              shift   <= mem[rd_ptr];
              div_lat <= bauddiv;
              state   <= START;
              txd     <= 1'b0;
            end else begin
              state <= IDLE;
              txd   <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

  // level interrupt: FIFO drained and serializer idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_int <= 1'b0;
    else     tx_int <= int_en & empty & ~busy;
  end

  // combinational read mux; unselected or write cycles return zero
  always_comb begin
    data_o = '0;
    if (ce & ~we) begin
      case (addr[3:2])
        2'd1: begin
          data_o[0]        = busy;
          data_o[1]        = full;
          data_o[2]        = empty;
          data_o[3]        = overflow;
          data_o[4 +: CW]  = count;
        end
        2'd2:    data_o[15:0] = bauddiv;
        2'd3:    data_o[1:0]  = {int_en, tx_en};
        default: data_o       = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// tb/tb_uart_tx_port.sv - directed self-checking bench for uart_tx_port
module tb_uart_tx_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce, we;
  logic [31:0] addr, data_i, data_o;
  logic [3:0]  sel;
  logic        txd, tx_int;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] A_TX   = 32'h0;
  localparam logic [31:0] A_STAT = 32'h4;
  localparam logic [31:0] A_BAUD = 32'h8;
  localparam logic [31:0] A_CTRL = 32'hC;

  uart_tx_port dut (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .we     (we),
    .addr   (addr),
    .sel    (sel),
    .data_i (data_i),
    .data_o (data_o),
    .txd    (txd),
    .tx_int (tx_int)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    ce = 1'b1; we = 1'b1; addr = a; data_i = d; sel = s;
    @(posedge clk);
    #1;
    ce = 1'b0; we = 1'b0; sel = 4'h0; data_i = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    ce = 1'b1; we = 1'b0; addr = a;
    #1;
    d = data_o;
    ce = 1'b0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // checks txd for ncyc cycles against stream bits, each held per clocks
  task automatic stream_check(input string tag, input logic [49:0] s, input int per, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      check(tag, {31'd0, txd}, {31'd0, s[k / per]});
      step();
    end
  endtask

  logic [31:0] rd;
  logic        seen_low, int_hi;
  logic [49:0] s;

  initial begin
    rst = 1'b1; ce = 1'b0; we = 1'b0; addr = '0; data_i = '0; sel = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_int", {31'd0, tx_int}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus_read(A_STAT, rd); check("rst_status", rd, 32'h4);
    bus_read(A_BAUD, rd); check("rst_baud", rd, 32'd433);
    bus_read(A_CTRL, rd); check("rst_ctrl", rd, 32'h1);
    bus_read(A_TX, rd);   check("rd_txdata", rd, 32'h0);
    check("idle_data_o", data_o, 32'h0);

    // single byte 0xA5 at BAUDDIV=3
    bus_write(A_BAUD, 32'h3, 4'b0011);
    bus_read(A_BAUD, rd); check("baud3", rd, 32'h3);
    bus_write(A_TX, 32'hA5, 4'b0001);
    bus_read(A_STAT, rd); check("one_cnt1", rd, 32'h10);
    step();
    bus_read(A_STAT, rd); check("one_popped", rd, 32'h5);
    s = '0; s[9:0] = {1'b1, 8'hA5, 1'b0};
    stream_check("one_bits", s, 4, 39);
    check("one_last_stop", {31'd0, txd}, 32'd1);
    bus_read(A_STAT, rd); check("one_busy_end", rd, 32'h5);
    step();
    bus_read(A_STAT, rd); check("one_idle", rd, 32'h4);

    // overflow with tx disabled, then back-to-back drain at BAUDDIV=0
    bus_write(A_BAUD, 32'h0, 4'b0011);
    bus_write(A_CTRL, 32'h0, 4'b0001);
    for (int i = 1; i <= 5; i++) bus_write(A_TX, i, 4'b0001);
    bus_write(A_TX, 32'h77, 4'b0000);
    bus_read(A_STAT, rd); check("full_status", rd, 32'h4A);
    check("full_txd_idle", {31'd0, txd}, 32'd1);
    bus_write(A_CTRL, 32'h1, 4'b0001);
    step();
    s = '0;
    s[39:0] = {1'b1, 8'h04, 1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 1'b0};
    stream_check("b2b_bits", s, 1, 40);
    bus_read(A_STAT, rd); check("b2b_done", rd, 32'hC);
    seen_low = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (txd !== 1'b1) seen_low = 1'b1;
      step();
    end
    check("b2b_no_fifth", {31'd0, seen_low}, 32'd0);
    bus_write(A_STAT, 32'h0, 4'b0000);
    bus_read(A_STAT, rd); check("ovf_clear", rd, 32'h4);

    // push on the same edge the FSM pops
    bus_write(A_CTRL, 32'h0, 4'b0001);
    bus_write(A_TX, 32'h11, 4'b0001);
    bus_write(A_CTRL, 32'h1, 4'b0001);
    bus_write(A_TX, 32'h22, 4'b0001);
    bus_read(A_STAT, rd); check("pp_count", rd, 32'h11);
    s = '0; s[19:0] = {1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0};
    stream_check("pp_bits", s, 1, 20);
    bus_read(A_STAT, rd); check("pp_done", rd, 32'h4);

    // interrupt at BAUDDIV=1
    bus_write(A_BAUD, 32'h1, 4'b0011);
    bus_write(A_CTRL, 32'h3, 4'b0001);
    step();
    check("int_idle_hi", {31'd0, tx_int}, 32'd1);
    bus_write(A_TX, 32'h5A, 4'b0001);
    check("int_still_hi", {31'd0, tx_int}, 32'd1);
    step();
    check("int_dropped", {31'd0, tx_int}, 32'd0);
    s = '0; s[9:0] = {1'b1, 8'h5A, 1'b0};
    int_hi = 1'b0;
    for (int k = 0; k < 20; k++) begin
      check("int_bits", {31'd0, txd}, {31'd0, s[k / 2]});
      if (tx_int !== 1'b0) int_hi = 1'b1;
      step();
    end
    check("int_low_frame", {31'd0, int_hi}, 32'd0);
    check("int_at_idle", {31'd0, tx_int}, 32'd0);
    step();
    check("int_rise", {31'd0, tx_int}, 32'd1);

    // reset during DATA bit 3 with another byte queued
    bus_write(A_BAUD, 32'h3, 4'b0011);
    bus_write(A_TX, 32'h00, 4'b0001);
    bus_write(A_TX, 32'h00, 4'b0001);
    repeat (16) @(posedge clk);
    #1;
    check("mid_bit3", {31'd0, txd}, 32'd0);
    bus_read(A_STAT, rd); check("mid_status", rd, 32'h11);
    #1;
    rst = 1'b1;
    #1;
    check("arst_txd", {31'd0, txd}, 32'd1);
    bus_read(A_STAT, rd); check("arst_status", rd, 32'h4);
    @(negedge clk);
    rst = 1'b0;
    bus_read(A_STAT, rd); check("post_status", rd, 32'h4);
    bus_read(A_BAUD, rd); check("post_baud", rd, 32'd433);
    bus_read(A_CTRL, rd); check("post_ctrl", rd, 32'h1);
    check("post_int", {31'd0, tx_int}, 32'd0);
    seen_low = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (txd !== 1'b1) seen_low = 1'b1;
      step();
    end
    check("post_no_resume", {31'd0, seen_low}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
